scene_compositor: RTL and testbench

Parametrised pixel compositor that replaces the fixed-priority per-stage colour mux in the VGA output path. It takes N sprite/overlay layers plus a background pixel and selects the highest-priority opaque layer through a 2-stage registered pipeline. It also owns the active scene register and runs frame-synchronous fade-out/fade-in transitions whenever upstream game logic requests a new scene. It sits between the sprite/text/background generators and the VGA_R/G/B pins.

---
 rtl/scene_compositor_if.sv | 27 ++
 rtl/scene_compositor.sv | 107 ++++++++++
 tb/tb_scene_compositor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/scene_compositor_if.sv
// Pixel and scene-control bundle between the layer generators, game logic and the
// compositor. The master drives layers and scene requests; the slave returns VGA colour.
interface scene_compositor_if #(
    parameter int N_LAYERS = 4,
    parameter int COLOR_W  = 8
);
    logic                            frame_start;
    logic [N_LAYERS-1:0]             layer_on;
    logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb;
    logic [3*COLOR_W-1:0]            bg_rgb;
    logic [1:0]                      scene_sel;
    logic [COLOR_W-1:0]              VGA_R;
    logic [COLOR_W-1:0]              VGA_G;
    logic [COLOR_W-1:0]              VGA_B;
    logic [1:0]                      scene_active;
    logic                            busy;

    modport master (
        output frame_start, layer_on, layer_rgb, bg_rgb, scene_sel,
        input  VGA_R, VGA_G, VGA_B, scene_active, busy
    );

    modport slave (
        input  frame_start, layer_on, layer_rgb, bg_rgb, scene_sel,
        output VGA_R, VGA_G, VGA_B, scene_active, busy
    );
endinterface

// File: rtl/scene_compositor.sv
// Two-stage priority layer compositor with frame-synchronous fade-out/fade-in
// between scenes; owns the active scene register.
module scene_compositor #(
    parameter int N_LAYERS  = 4,
    parameter int COLOR_W   = 8,
    parameter int FADE_LOG2 = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    scene_compositor_if.slave   bus
);
    localparam int PIX_W  = 3 * COLOR_W;
    localparam int LVL_W  = FADE_LOG2 + 1;
    localparam int PROD_W = COLOR_W + FADE_LOG2 + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(2 ** FADE_LOG2);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_OUT = 2'd1;
    localparam logic [1:0] ST_FADE_IN  = 2'd2;

    logic [1:0]       state;
    logic [LVL_W-1:0] lvl;
    logic [1:0]       scene_active;
    logic [1:0]       pending;
    logic [PIX_W-1:0] pick_rgb;
    logic [PIX_W-1:0] stage1_rgb;
    logic [PIX_W-1:0] faded_rgb;
    logic [PIX_W-1:0] stage2_rgb;

    function automatic logic [COLOR_W-1:0] fade(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W-1:0]   l);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(l);
        return COLOR_W'(prod >> FADE_LOG2);
    endfunction

    // Scan from lowest priority upward so the lowest opaque index is written last.
    // NOTE: pick_rgb gets its default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        pick_rgb = bus.bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_on[i]) pick_rgb = bus.layer_rgb[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        faded_rgb = '0;
        for (int ch = 0; ch < 3; ch++) begin
            faded_rgb[ch*COLOR_W +: COLOR_W] = fade(stage1_rgb[ch*COLOR_W +: COLOR_W], lvl);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stage1_rgb <= '0;
            stage2_rgb <= '0;
        end else begin
            stage1_rgb <= pick_rgb;
            stage2_rgb <= faded_rgb;
        end
    end

    // lvl only moves on frame_start, so brightness is constant within a frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            lvl          <= LVL_MAX;
            scene_active <= 2'd0;
            pending      <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lvl <= LVL_MAX;
                    if (bus.scene_sel != scene_active) begin
                        pending <= bus.scene_sel;
                        state   <= ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    pending <= bus.scene_sel;
                    if (bus.frame_start) begin
                        if (lvl != '0) begin
                            lvl <= lvl - 1'b1;
                        end else begin
                            scene_active <= pending;
                            state        <= ST_FADE_IN;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (bus.frame_start) begin
                        lvl <= lvl + 1'b1;
                        if (lvl == LVL_MAX - 1'b1) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.VGA_R        = stage2_rgb[2*COLOR_W +: COLOR_W];
    assign bus.VGA_G        = stage2_rgb[COLOR_W +: COLOR_W];
    assign bus.VGA_B        = stage2_rgb[0 +: COLOR_W];
    assign bus.scene_active = scene_active;
    assign bus.busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_scene_compositor.sv
// Directed bench for scene_compositor: default instance for priority, fade and scene
// sequencing, plus a narrow 8-layer instance for the alternate parameter set.
module tb_scene_compositor;
    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    scene_compositor_if #(.N_LAYERS(4), .COLOR_W(8)) b ();
    scene_compositor_if #(.N_LAYERS(8), .COLOR_W(5)) b2 ();

    scene_compositor #(.N_LAYERS(4), .COLOR_W(8), .FADE_LOG2(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b.slave));
    scene_compositor #(.N_LAYERS(8), .COLOR_W(5), .FADE_LOG2(3)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b2.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame: a single-cycle frame_start pulse then three blank cycles.
    task automatic frame(input int n);
        repeat (n) begin
            b.frame_start  = 1'b1;
            b2.frame_start = 1'b1;
            @(negedge Clk);
            b.frame_start  = 1'b0;
            b2.frame_start = 1'b0;
            step(3);
        end
    endtask

    function automatic logic [31:0] vga();
        return {8'h00, b.VGA_R, b.VGA_G, b.VGA_B};
    endfunction

    function automatic logic [31:0] vga2();
        return {17'h0, b2.VGA_R, b2.VGA_G, b2.VGA_B};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        Reset_n = 1'b0;
        b.frame_start = 1'b0;
        b.layer_on    = 4'b0000;
        b.layer_rgb   = {24'h123456, 24'h00FF00, 24'hFF0000, 24'h0000FF};
        b.bg_rgb      = 24'h102030;
        b.scene_sel   = 2'd0;
        b2.frame_start = 1'b0;
        b2.layer_on    = 8'h00;
        b2.layer_rgb   = '0;
        b2.bg_rgb      = '0;
        b2.scene_sel   = 2'd0;

        step(2);
        check("reset_vga", vga(), 32'h0);
        check("reset_busy", {31'h0, b.busy}, 32'h0);
        check("reset_scene", {30'h0, b.scene_active}, 32'h0);

        Reset_n = 1'b1;
        step(2);
        check("bg_after_release", vga(), 32'h102030);
        check("idle_busy", {31'h0, b.busy}, 32'h0);
        check("idle_scene", {30'h0, b.scene_active}, 32'h0);

        b.layer_on = 4'b0110;
        step(2);
        check("layer1_wins", vga(), 32'hFF0000);
        b.layer_on = 4'b1111;
        step(2);
        check("layer0_wins", vga(), 32'h0000FF);
        b.layer_on = 4'b1000;
        step(2);
        check("layer3_only", vga(), 32'h123456);
        b.layer_on = 4'b0000;
        step(2);
        check("back_to_bg", vga(), 32'h102030);

        // First transition 0 -> 1 on a white background.
        b.bg_rgb = 24'hFFFFFF;
        step(2);
        b.scene_sel = 2'd1;
        step(1);
        check("busy_rises", {31'h0, b.busy}, 32'h1);
        frame(8);
        check("half_fade", vga(), 32'h7F7F7F);
        check("scene_held", {30'h0, b.scene_active}, 32'h0);
        frame(8);
        check("black_at_16", vga(), 32'h0);
        check("scene_before_swap", {30'h0, b.scene_active}, 32'h0);
        frame(1);
        check("swap_scene", {30'h0, b.scene_active}, 32'h1);
        check("swap_black", vga(), 32'h0);
        frame(7);
        check("fade_in_7", vga(), 32'h6F6F6F);
        frame(8);
        check("fade_in_15_busy", {31'h0, b.busy}, 32'h1);
        frame(1);
        check("done_busy", {31'h0, b.busy}, 32'h0);
        check("done_white", vga(), 32'hFFFFFF);

        // Request coinciding with frame_start must not decrement.
        b.scene_sel    = 2'd2;
        b.frame_start  = 1'b1;
        b2.frame_start = 1'b1;
        step(1);
        b.frame_start  = 1'b0;
        b2.frame_start = 1'b0;
        step(3);
        check("coincident_no_dec", vga(), 32'hFFFFFF);
        check("coincident_busy", {31'h0, b.busy}, 32'h1);
        frame(1);
        check("first_dec", vga(), 32'hEFEFEF);
        b.scene_sel = 2'd3;
        frame(15);
        check("out_black_2", vga(), 32'h0);
        frame(1);
        check("latest_wins", {30'h0, b.scene_active}, 32'h3);
        b.scene_sel = 2'd2;
        frame(8);
        check("fade_in_ignores_sel", {30'h0, b.scene_active}, 32'h3);
        frame(8);
        check("second_trans_busy", {31'h0, b.busy}, 32'h1);
        check("second_trans_full", vga(), 32'hFFFFFF);
        check("second_trans_scene", {30'h0, b.scene_active}, 32'h3);
        frame(17);
        check("second_swap", {30'h0, b.scene_active}, 32'h2);
        frame(16);
        check("second_done_busy", {31'h0, b.busy}, 32'h0);
        check("second_done_white", vga(), 32'hFFFFFF);

        // Asynchronous reset in the middle of a fade-out at lvl 5.
        b.scene_sel = 2'd0;
        step(1);
        frame(11);
        check("lvl5", vga(), 32'h4F4F4F);
        #2 Reset_n = 1'b0;
        #1;
        check("async_vga", vga(), 32'h0);
        check("async_busy", {31'h0, b.busy}, 32'h0);
        check("async_scene", {30'h0, b.scene_active}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step(2);
        check("post_reset_full", vga(), 32'hFFFFFF);
        check("post_reset_idle", {31'h0, b.busy}, 32'h0);

        // Narrow instance: 8 layers, 5-bit colour, 8 fade steps.
        b2.layer_rgb[119:105] = {5'd31, 5'd31, 5'd31};
        b2.layer_rgb[14:0]    = {5'd1, 5'd2, 5'd3};
        b2.layer_on  = 8'h80;
        b2.scene_sel = 2'd1;
        step(2);
        check("n8_layer7_full", vga2(), {17'h0, 5'd31, 5'd31, 5'd31});
        frame(4);
        check("n8_lvl4", vga2(), {17'h0, 5'd15, 5'd15, 5'd15});
        b2.layer_on = 8'h00;
        b2.bg_rgb   = {5'd8, 5'd16, 5'd24};
        step(2);
        check("n8_bg_lvl4", vga2(), {17'h0, 5'd4, 5'd8, 5'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
